ring_decoder: RTL and testbench
===============================

# ring_decoder

Receive-side companion to the team's one-hot ring counter. It samples the ring's `q` bus, converts the one-hot value to a binary index and tracks rotation legality with a hunt/sync/lock state machine. It flags illegal, skipped and stalled steps, and counts completed revolutions. It sits downstream of the ring counter as its checker and position decoder.

## Interface
- `WIDTH`, 4: ring length in bits; must be ≥ 2.
- `LOCK_CNT`, 2: consecutive correct rotations required to reach LOCK; must be ≥ 1.
- `REV_W`, 8: revolution counter width.
- Derived localparam `IDXW` = $clog2(`WIDTH`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `q`  in  `WIDTH`  one-hot ring value; bit moves upward each step: 0001→0010→0100→1000→0001.
- `idx`  out  `IDXW`  index of the set bit of the last legal sample.
- `valid`  out  1  last sample was legal one-hot.
- `locked`  out  1  FSM is in LOCK.
- `err`  out  1  one-cycle pulse on any deviation while in LOCK.
- `err_code`  out  2  cause of the last `err`: 01 ILLEGAL, 10 SKIP, 11 STALL; 00 after reset.
- `rev_cnt`  out  `REV_W`  completed revolutions while locked; wraps modulo 2^`REV_W`.
- `rev_tick`  out  1  one-cycle pulse when `rev_cnt` increments.

## Operation
- Legal sample: exactly one bit of `q` set. Zero bits set or more than one bit set is ILLEGAL.
- Expected next value: `exp` = {`prev`[`WIDTH`-2:0], `prev`[`WIDTH`-1]}, where `prev` is the last legal sample.
- HUNT state:
  - Legal sample → go to SYNC, store `prev`, clear `good_cnt`.
  - Illegal sample → stay in HUNT; no `err`.
- SYNC state:
  - `q` == `exp` → increment `good_cnt`. When `good_cnt` reaches `LOCK_CNT`, go to LOCK.
  - Legal but `q` != `exp` → stay in SYNC and clear `good_cnt`; no `err`.
  - Illegal sample → go to HUNT.
- LOCK state:
  - `q` == `exp` → stay in LOCK.
  - ILLEGAL → `err`=1, `err_code`=01, go to HUNT.
  - `q` == `prev` → STALL: `err`=1, `err_code`=11, go to SYNC with `good_cnt`=0.
  - Any other legal value → SKIP: `err`=1, `err_code`=10, go to SYNC with `good_cnt`=0.
- `prev` is updated on every legal sample in every state.
- `idx` and `valid`:
  - `valid` follows legality of the current sample.
  - `idx` updates only on a legal sample; it holds its value while `valid`=0.
- Revolution counting: in LOCK, a correct step from index `WIDTH`-1 to index 0 increments `rev_cnt` and pulses `rev_tick`.
- `rev_cnt` holds its value when lock is lost and is cleared only by reset.
- `err_code` holds its value until the next `err`.
- `err` is never raised outside LOCK.

## Timing
- All outputs are registered.
- `q` sampled at rising edge k → `idx`, `valid`, `locked`, `err`, `rev_tick` reflect that sample after edge k (one-cycle latency).
- The ring counter updates on the falling edge, so `q` is stable at the rising edge. No synchronizer is included; `clk` is the same clock as the ring counter's.
- Reset values, applied at the first rising edge with `reset`=0:
  - FSM = HUNT; `good_cnt` = 0; `prev` = 0.
  - `idx` = 0, `valid` = 0, `locked` = 0, `err` = 0, `err_code` = 00, `rev_cnt` = 0, `rev_tick` = 0.
- Reset takes priority over all other events, including a reset asserted mid-LOCK.
- The transition into LOCK occurs on the edge that sees the `LOCK_CNT`-th correct step. `locked`=1 is visible after that edge.
- A deviation that coincides with a wrap step (index `WIDTH`-1 to 0) is reported as an error. `rev_tick` stays 0 in that case.

## Structure
- Shared package `ring_pkg` holds:
  - the state enum (HUNT, SYNC, LOCK);
  - the `err_code` constants (ERR_NONE, ERR_ILLEGAL, ERR_SKIP, ERR_STALL);
  - a rotate-left function parameterised by width.
- One sub-module: `ring_onehot_enc`. It is combinational and maps `q` → {`legal`, `index`}. It is reusable by other ring consumers.
- Top level holds the FSM, `prev`, `good_cnt`, `rev_cnt` and the output registers.

## Test plan
All scenarios use `WIDTH`=4, `LOCK_CNT`=2, `REV_W`=8.
1. Reset: hold `reset`=0 for 3 edges with `q`=0001 → every output is 0 and the FSM is in HUNT.
2. Clean rotation: release reset, drive 0001, 0010, 0100, 1000, 0001 → `valid`=1 and `idx`=0,1,2,3,0. `locked` rises after the 0100 sample. `rev_tick` pulses once on the 1000→0001 step and `rev_cnt`=1. After 255 further revolutions, `rev_cnt` wraps to 0.
3. Stall in LOCK: 0100, 0100 → one-cycle `err`, `err_code`=11, `locked`=0. Resume 1000, 0001, 0010 → relock after 0001.
4. Illegal in LOCK: 0110 → `err`, `err_code`=01, `valid`=0, `idx` holds, FSM in HUNT. Then 0000, 1001 → no further `err`.
5. Skip in LOCK: 0001 then 0100 → `err`, `err_code`=10, `idx`=2, `locked`=0, `rev_cnt` unchanged.
6. Reset mid-lock with `rev_cnt`=5: `reset`=0 for one edge → all outputs 0 after that edge, then re-lock from HUNT per scenario 2.

Source files
------------

// File: rtl/ring_pkg.sv
// ring_pkg: shared types and helpers for ring counter consumers.
//   ring_state_e : decoder FSM states (HUNT, SYNC, LOCK)
//   ERR_*        : err_code values reported by the decoder
//   ring_rotl    : rotate-left-by-one of the low w bits of a vector
package ring_pkg;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOCK = 2'd2
  } ring_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_SKIP    = 2'b10;
  localparam logic [1:0] ERR_STALL   = 2'b11;

  // Widest ring the helper supports; callers zero-extend into this width.
  localparam int RING_MAXW = 64;

  // Bit i of the low w bits moves to bit i+1, top bit wraps to bit 0.
  // Bits at or above w are returned as zero.
  function automatic logic [RING_MAXW-1:0] ring_rotl(input logic [RING_MAXW-1:0] v,
                                                     input int w);
    logic [RING_MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < RING_MAXW; i++) begin
      if (i < w) r[(i == w - 1) ? 0 : i + 1] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_decoder_if.sv
// ring_decoder_if: ring sample in, decoded position/status out.
//   q        : one-hot ring value (driven by the ring side)
//   idx      : index of last legal sample
//   valid    : last sample was legal
//   locked   : decoder is in LOCK
//   err      : one-cycle deviation pulse while locked
//   err_code : cause of the last err
//   rev_cnt  : completed revolutions while locked
//   rev_tick : one-cycle pulse on rev_cnt increment
interface ring_decoder_if #(
  parameter int WIDTH = 4,
  parameter int REV_W = 8
);
  localparam int IDXW = $clog2(WIDTH);

  logic [WIDTH-1:0] q;
  logic [IDXW-1:0]  idx;
  logic             valid;
  logic             locked;
  logic             err;
  logic [1:0]       err_code;
  logic [REV_W-1:0] rev_cnt;
  logic             rev_tick;

  modport master (
    output q,
    input  idx, valid, locked, err, err_code, rev_cnt, rev_tick
  );

  modport slave (
    input  q,
    output idx, valid, locked, err, err_code, rev_cnt, rev_tick
  );
endinterface

// File: rtl/ring_onehot_enc.sv
// ring_onehot_enc: combinational one-hot to binary encoder.
//   i_q     : ring value
//   o_legal : exactly one bit of i_q set
//   o_index : position of the set bit (meaningful only when o_legal)
module ring_onehot_enc #(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_q,
  output logic             o_legal,
  output logic [IDXW-1:0]  o_index
);

  // Clearing the lowest set bit leaves zero only for a single-bit value.
  assign o_legal = (i_q != '0) && ((i_q & (i_q - WIDTH'(1))) == '0);

  always_comb begin
    o_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_q[i]) o_index = o_index | IDXW'(i);
    end
  end

endmodule

// File: rtl/ring_decoder.sv
// ring_decoder: checks one-hot ring rotation and decodes its position.
//   clk   : clock, rising-edge
//   reset : synchronous, active-low
//   bus   : ring_decoder_if.slave (q in; idx/valid/locked/err/err_code/rev_cnt/rev_tick out)
//
// state | meaning
// HUNT  | waiting for any legal one-hot sample
// SYNC  | counting consecutive correct steps toward LOCK
// LOCK  | rotation trusted; deviations raise err, wraps count revolutions
module ring_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int REV_W    = 8
) (
  input  logic           clk,
  input  logic           reset,
  ring_decoder_if.slave  bus
);

  localparam int IDXW = $clog2(WIDTH);
  localparam int GW   = $clog2(LOCK_CNT + 1);

  ring_state_e      r_state;
  logic [WIDTH-1:0] r_prev;
  logic [GW-1:0]    r_good;
  logic [IDXW-1:0]  r_idx;
  logic             r_valid;
  logic             r_locked;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic [REV_W-1:0] r_rev_cnt;
  logic             r_rev_tick;

  logic             w_legal;
  logic [IDXW-1:0]  w_index;
  logic [WIDTH-1:0] w_exp;
  logic             w_match;
  logic             w_stall;

  ring_onehot_enc #(.WIDTH(WIDTH), .IDXW(IDXW)) u_enc (
    .i_q     (bus.q),
    .o_legal (w_legal),
    .o_index (w_index)
  );

  // r_prev is zero only straight after reset, so w_exp is zero then and
  // can never match a legal sample.
  assign w_exp   = WIDTH'(ring_rotl(RING_MAXW'(r_prev), WIDTH));
  assign w_match = w_legal && (bus.q == w_exp);
  assign w_stall = w_legal && (bus.q == r_prev);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_HUNT;
      r_prev     <= '0;
      r_good     <= '0;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_rev_cnt  <= '0;
      r_rev_tick <= 1'b0;
    end else begin
      r_valid    <= w_legal;
      r_err      <= 1'b0;
      r_rev_tick <= 1'b0;
      if (w_legal) begin
        r_prev <= bus.q;
        r_idx  <= w_index;
      end
      case (r_state)
        ST_HUNT: begin
          if (w_legal) begin
            r_state <= ST_SYNC;
            r_good  <= '0;
          end
        end
        ST_SYNC: begin
          if (!w_legal) begin
            r_state <= ST_HUNT;
          end else if (w_match) begin
            r_good <= r_good + 1'b1;
            if (r_good == GW'(LOCK_CNT - 1)) begin
              r_state  <= ST_LOCK;
              r_locked <= 1'b1;
            end
          end else begin
            r_good <= '0;
          end
        end
        ST_LOCK: begin
          if (w_match) begin
            // A correct step out of the top bit completes a revolution.
            if (r_prev[WIDTH-1]) begin
              r_rev_cnt  <= r_rev_cnt + 1'b1;
              r_rev_tick <= 1'b1;
            end
          end else begin
            r_err    <= 1'b1;
            r_locked <= 1'b0;
            r_good   <= '0;
            if (!w_legal) begin
              r_err_code <= ERR_ILLEGAL;
              r_state    <= ST_HUNT;
            end else if (w_stall) begin
              r_err_code <= ERR_STALL;
              r_state    <= ST_SYNC;
            end else begin
              r_err_code <= ERR_SKIP;
              r_state    <= ST_SYNC;
            end
          end
        end
        default: begin
          r_state  <= ST_HUNT;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign bus.idx      = r_idx;
  assign bus.valid    = r_valid;
  assign bus.locked   = r_locked;
  assign bus.err      = r_err;
  assign bus.err_code = r_err_code;
  assign bus.rev_cnt  = r_rev_cnt;
  assign bus.rev_tick = r_rev_tick;

endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder: directed scenarios for ring_decoder (WIDTH=4, LOCK_CNT=2,
// REV_W=8) with an index-level reference model checked every cycle and
// hand-computed expectations at key points.
module tb_ring_decoder;

  localparam int W  = 4;
  localparam int LC = 2;
  localparam int RW = 8;

  localparam int M_HUNT = 0;
  localparam int M_SYNC = 1;
  localparam int M_LOCK = 2;

  logic clk;
  logic reset;

  ring_decoder_if #(.WIDTH(W), .REV_W(RW)) bus ();

  ring_decoder #(.WIDTH(W), .LOCK_CNT(LC), .REV_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: tracks positions as integer indices, prev = -1 means none.
  int m_st, m_prev, m_good, m_idx, m_code, m_rev;
  bit m_valid, m_locked, m_err, m_tick;
  int m_cnt, m_qi, m_ex;
  bit m_lg;

  always @(posedge clk) begin
    if (!reset) begin
      m_st = M_HUNT; m_prev = -1; m_good = 0; m_idx = 0; m_code = 0; m_rev = 0;
      m_valid = 0; m_locked = 0; m_err = 0; m_tick = 0;
    end else begin
      m_cnt = $countones(bus.q);
      m_lg  = (m_cnt == 1);
      m_qi  = 0;
      for (int i = 0; i < W; i++) if (bus.q[i]) m_qi = i;
      m_ex  = (m_prev < 0) ? -1 : (m_prev + 1) % W;
      m_err = 0; m_tick = 0; m_valid = m_lg;
      if (m_st == M_HUNT) begin
        if (m_lg) begin m_st = M_SYNC; m_good = 0; end
      end else if (m_st == M_SYNC) begin
        if (!m_lg) m_st = M_HUNT;
        else if (m_qi == m_ex) begin
          m_good++;
          if (m_good >= LC) m_st = M_LOCK;
        end else m_good = 0;
      end else begin
        if (!m_lg) begin
          m_err = 1; m_code = 1; m_st = M_HUNT;
        end else if (m_qi == m_ex) begin
          if (m_prev == W - 1) begin m_rev = (m_rev + 1) % (1 << RW); m_tick = 1; end
        end else if (m_qi == m_prev) begin
          m_err = 1; m_code = 3; m_st = M_SYNC; m_good = 0;
        end else begin
          m_err = 1; m_code = 2; m_st = M_SYNC; m_good = 0;
        end
      end
      if (m_lg) begin m_prev = m_qi; m_idx = m_qi; end
      m_locked = (m_st == M_LOCK);
    end
    #1;
    chk("cyc_idx",      32'(bus.idx),      32'(m_idx));
    chk("cyc_valid",    32'(bus.valid),    32'(m_valid));
    chk("cyc_locked",   32'(bus.locked),   32'(m_locked));
    chk("cyc_err",      32'(bus.err),      32'(m_err));
    chk("cyc_err_code", 32'(bus.err_code), 32'(m_code));
    chk("cyc_rev_cnt",  32'(bus.rev_cnt),  32'(m_rev));
    chk("cyc_rev_tick", 32'(bus.rev_tick), 32'(m_tick));
  end

  task automatic step(input logic [W-1:0] v);
    @(negedge clk);
    bus.q = v;
    @(posedge clk);
    #2;
  endtask

  task automatic rev_once();
    step(4'b0010); step(4'b0100); step(4'b1000); step(4'b0001);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_idx"},      32'(bus.idx),      0);
    chk({tag, "_valid"},    32'(bus.valid),    0);
    chk({tag, "_locked"},   32'(bus.locked),   0);
    chk({tag, "_err"},      32'(bus.err),      0);
    chk({tag, "_err_code"}, 32'(bus.err_code), 0);
    chk({tag, "_rev_cnt"},  32'(bus.rev_cnt),  0);
    chk({tag, "_rev_tick"}, 32'(bus.rev_tick), 0);
  endtask

  initial begin
    reset = 1'b0;
    bus.q = 4'b0001;

    // 1: reset held
    repeat (3) step(4'b0001);
    chk_all_zero("rst");

    // 2: clean rotation and rev_cnt wrap
    reset = 1'b1;
    step(4'b0001); chk("s2_idx0", 32'(bus.idx), 0); chk("s2_valid0", 32'(bus.valid), 1);
                   chk("s2_lock0", 32'(bus.locked), 0);
    step(4'b0010); chk("s2_idx1", 32'(bus.idx), 1); chk("s2_lock1", 32'(bus.locked), 0);
    step(4'b0100); chk("s2_idx2", 32'(bus.idx), 2); chk("s2_lock2", 32'(bus.locked), 1);
    step(4'b1000); chk("s2_idx3", 32'(bus.idx), 3); chk("s2_tick3", 32'(bus.rev_tick), 0);
    step(4'b0001); chk("s2_idx4", 32'(bus.idx), 0); chk("s2_tick4", 32'(bus.rev_tick), 1);
                   chk("s2_rev1", 32'(bus.rev_cnt), 1);
    repeat (255) rev_once();
    chk("s2_rev_wrap", 32'(bus.rev_cnt), 0);
    chk("s2_tick_wrap", 32'(bus.rev_tick), 1);

    // 3: stall in LOCK, then relock
    step(4'b0010); step(4'b0100);
    step(4'b0100);
    chk("s3_err", 32'(bus.err), 1); chk("s3_code", 32'(bus.err_code), 3);
    chk("s3_lock", 32'(bus.locked), 0); chk("s3_idx", 32'(bus.idx), 2);
    step(4'b1000); chk("s3_err_off", 32'(bus.err), 0); chk("s3_code_hold", 32'(bus.err_code), 3);
                   chk("s3_lock_a", 32'(bus.locked), 0);
    step(4'b0001); chk("s3_relock", 32'(bus.locked), 1); chk("s3_no_tick", 32'(bus.rev_tick), 0);
    step(4'b0010); chk("s3_lock_b", 32'(bus.locked), 1);

    // 4: illegal in LOCK
    step(4'b0110);
    chk("s4_err", 32'(bus.err), 1); chk("s4_code", 32'(bus.err_code), 1);
    chk("s4_valid", 32'(bus.valid), 0); chk("s4_idx_hold", 32'(bus.idx), 1);
    chk("s4_lock", 32'(bus.locked), 0);
    step(4'b0000); chk("s4_err_zero", 32'(bus.err), 0); chk("s4_idx_hold2", 32'(bus.idx), 1);
    step(4'b1001); chk("s4_err_multi", 32'(bus.err), 0); chk("s4_code_hold", 32'(bus.err_code), 1);

    // 5: skip in LOCK
    step(4'b0100); step(4'b1000);
    step(4'b0001); chk("s5_lock", 32'(bus.locked), 1);
    rev_once(); rev_once();
    chk("s5_rev", 32'(bus.rev_cnt), 2);
    step(4'b0100);
    chk("s5_err", 32'(bus.err), 1); chk("s5_code", 32'(bus.err_code), 2);
    chk("s5_idx", 32'(bus.idx), 2); chk("s5_lock0", 32'(bus.locked), 0);
    chk("s5_rev_hold", 32'(bus.rev_cnt), 2);

    // 6: reset mid-lock
    step(4'b1000);
    step(4'b0001); chk("s6_lock", 32'(bus.locked), 1);
    rev_once(); rev_once(); rev_once();
    chk("s6_rev5", 32'(bus.rev_cnt), 5);
    reset = 1'b0;
    step(4'b0010);
    chk_all_zero("s6_rst");
    reset = 1'b1;
    step(4'b0001); step(4'b0010);
    step(4'b0100); chk("s6_relock", 32'(bus.locked), 1);
    step(4'b1000);
    step(4'b0001); chk("s6_rev1", 32'(bus.rev_cnt), 1); chk("s6_tick", 32'(bus.rev_tick), 1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
